// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: shared segment type, blank value and hex decode table.
// Segment byte layout: bit 7 = dp, bits 6:0 = g..a, active-low.
package seven_segment_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // Entry i is the pattern for hex value i, dp off.
  localparam seg_t [15:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: nibble + dot + blank -> active-low segment byte.
// Ports: nibble (hex value), dot (1 = lit), blank (forces all off), seg.
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dot,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_LUT[nibble];
    if (dot) seg[7] = 1'b0;
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/seven_segment_display.sv
// seven_segment_display: static or scanned 7-seg driver with load capture.
// Ports: clk, reset_n, load, data, dots, digit_en, blink -> hex | seg, dig_sel.
// Build option: YRV_SEVEN_SEG_BLINK_EN adds the per-digit blink counter.
module seven_segment_display
  import seven_segment_pkg::*;
#(
  parameter int n_digits          = 6,
  parameter int multiplexed       = 0,
  parameter int scan_period       = 50000,
  parameter int blink_half_period = 12500000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*n_digits-1:0] data,
  input  logic [n_digits-1:0]   dots,
  input  logic [n_digits-1:0]   digit_en,
  input  logic [n_digits-1:0]   blink,
  output logic [8*n_digits-1:0] hex,
  output logic [7:0]            seg,
  output logic [n_digits-1:0]   dig_sel
);

  logic [4*n_digits-1:0] data_q;
  logic [n_digits-1:0]   dots_q;
  logic [n_digits-1:0]   en_q;
  logic [n_digits-1:0]   blink_off;
  logic [n_digits-1:0]   digit_off;

`ifdef YRV_SEVEN_SEG_BLINK_EN
  localparam int BW = $clog2(blink_half_period);

  logic [n_digits-1:0] blink_q;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q <= '0;
    end else if (load) begin
      blink_q <= blink;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(blink_half_period - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_off = blink_q & {n_digits{blink_phase}};
`else
  localparam int unused_half = blink_half_period;

  logic unused_blink;
  assign unused_blink = ^blink;
  assign blink_off    = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      dots_q <= '0;
      en_q   <= '0;
    end else if (load) begin
      data_q <= data;
      dots_q <= dots;
      en_q   <= digit_en;
    end
  end

  assign digit_off = ~en_q | blink_off;

  generate
    if (multiplexed == 0) begin : g_static
      localparam int unused_scan = scan_period;

      seg_t dec_seg [n_digits];

      for (genvar i = 0; i < n_digits; i++) begin : g_dec
        seven_segment_decoder u_dec (
          .nibble (data_q[4*i +: 4]),
          .dot    (dots_q[i]),
          .blank  (digit_off[i]),
          .seg    (dec_seg[i])
        );
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hex <= '1;
        end else begin
          for (int i = 0; i < n_digits; i++) begin
            hex[8*i +: 8] <= dec_seg[i];
          end
        end
      end

      assign seg     = SEG_BLANK;
      assign dig_sel = '1;
    end else begin : g_scan
      localparam int SW = $clog2(scan_period);
      localparam int IW = (n_digits > 1) ? $clog2(n_digits) : 1;

      logic [SW-1:0]       scan_cnt;
      logic [IW-1:0]       idx;
      logic                wrap;
      logic [3:0]          cur_nib;
      logic                cur_dot;
      logic                cur_off;
      logic [n_digits-1:0] cur_sel;
      seg_t                cur_seg;

      assign wrap = (scan_cnt == SW'(scan_period - 1));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          scan_cnt <= '0;
          idx      <= '0;
        end else if (wrap) begin
          scan_cnt <= '0;
          if (idx == IW'(n_digits - 1)) idx <= '0;
          else idx <= idx + 1'b1;
        end else begin
          scan_cnt <= scan_cnt + 1'b1;
        end
      end

      always_comb begin
        cur_nib = '0;
        cur_dot = 1'b0;
        cur_off = 1'b1;
        cur_sel = '1;
        for (int i = 0; i < n_digits; i++) begin
          if (IW'(i) == idx) begin
            cur_nib    = data_q[4*i +: 4];
            cur_dot    = dots_q[i];
            cur_off    = digit_off[i];
            cur_sel[i] = 1'b0;
          end
        end
      end

      seven_segment_decoder u_dec (
        .nibble (cur_nib),
        .dot    (cur_dot),
        .blank  (cur_off),
        .seg    (cur_seg)
      );

      // Last counter value of a slot drives the guard: select and
      // segments both off while the index moves to the next digit.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          seg     <= SEG_BLANK;
          dig_sel <= '1;
        end else if (wrap) begin
          seg     <= SEG_BLANK;
          dig_sel <= '1;
        end else begin
          seg     <= cur_seg;
          dig_sel <= cur_sel;
        end
      end

      assign hex = '1;
    end
  endgenerate

endmodule

// File: tb/tb_seven_segment_display.sv
// tb_seven_segment_display: directed checks of static and scanned builds.
// Ports: none; drives one static (6 digit) and one scanned (4 digit) DUT.
module tb_seven_segment_display;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic        s_load = 1'b0;
  logic [23:0] s_data = '0;
  logic [5:0]  s_dots = '0;
  logic [5:0]  s_en = '0;
  logic [5:0]  s_blink = '0;
  logic [47:0] s_hex;
  logic [7:0]  s_seg;
  logic [5:0]  s_dig;

  logic        m_load = 1'b0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dots = '0;
  logic [3:0]  m_en = '0;
  logic [3:0]  m_blink = '0;
  logic [31:0] m_hex;
  logic [7:0]  m_seg;
  logic [3:0]  m_dig;

  int checks = 0;
  int failures = 0;
  int cyc;

  seven_segment_display #(
    .n_digits(6), .multiplexed(0),
    .scan_period(4), .blink_half_period(8)
  ) u_static (
    .clk(clk), .reset_n(rst_n), .load(s_load),
    .data(s_data), .dots(s_dots), .digit_en(s_en),
    .blink(s_blink), .hex(s_hex), .seg(s_seg),
    .dig_sel(s_dig)
  );

  seven_segment_display #(
    .n_digits(4), .multiplexed(1),
    .scan_period(4), .blink_half_period(8)
  ) u_scan (
    .clk(clk), .reset_n(rst_n), .load(m_load),
    .data(m_data), .dots(m_dots), .digit_en(m_en),
    .blink(m_blink), .hex(m_hex), .seg(m_seg),
    .dig_sel(m_dig)
  );

  // Rising edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic logic [7:0] dec(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9;
      4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92;
      4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90;
      4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1;
      4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  // {dig_sel, seg} of the 4-digit scanned DUT, scan_period 4,
  // all digits enabled, no dots, m rising edges after reset.
  function automatic logic [11:0] scan_model(
    input int m, input logic [15:0] d);
    int c;
    int k;
    logic [3:0] sel;
    logic [7:0] sg;
    if (m == 0) return {4'hF, 8'hFF};
    c = (m - 1) % 4;
    if (c == 3) return {4'hF, 8'hFF};
    k = ((m - 1) / 4) % 4;
    sel = 4'hF;
    sel[k] = 1'b0;
    sg = dec(d[4*k +: 4]);
    return {sel, sg};
  endfunction

  task automatic s_load_val(input logic [23:0] d,
    input logic [5:0] dp, input logic [5:0] en,
    input logic [5:0] bl);
    s_load = 1'b1; s_data = d; s_dots = dp;
    s_en = en; s_blink = bl;
    @(posedge clk); #1;
    s_load = 1'b0;
  endtask

  task automatic m_load_val(input logic [15:0] d,
    input logic [3:0] en);
    m_load = 1'b1; m_data = d; m_dots = '0;
    m_en = en; m_blink = '0;
    @(posedge clk); #1;
    m_load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_hex !== {48{1'b1}}) begin
      failures++;
      $display("FAIL reset_hex: got %h want all ones", s_hex);
    end
    checks++;
    if ({s_seg, s_dig} !== 14'h3FFF) begin
      failures++;
      $display("FAIL reset_static_bus: got %h/%h want ff/3f",
        s_seg, s_dig);
    end
    checks++;
    if ({m_seg, m_dig} !== 12'hFFF || m_hex !== '1) begin
      failures++;
      $display("FAIL reset_scan: got %h/%h/%h want ff/f/ones",
        m_seg, m_dig, m_hex);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_static_decode;
    logic [47:0] exp;
    exp = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
    s_load_val(24'h012345, 6'h00, 6'h3F, 6'h00);
    @(negedge clk);
    checks++;
    if (s_hex !== {48{1'b1}}) begin
      failures++;
      $display("FAIL load_latency: got %h want all ones", s_hex);
    end
    @(negedge clk);
    checks++;
    if (s_hex !== exp) begin
      failures++;
      $display("FAIL decode_012345: got %h want %h", s_hex, exp);
    end
    checks++;
    if ({s_seg, s_dig} !== 14'h3FFF) begin
      failures++;
      $display("FAIL static_bus_idle: got %h/%h want ff/3f",
        s_seg, s_dig);
    end
    exp = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h19, 8'h92};
    s_load_val(24'h012345, 6'b000010, 6'h3F, 6'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (s_hex !== exp) begin
      failures++;
      $display("FAIL decode_dot: got %h want %h", s_hex, exp);
    end
  endtask

  task automatic test_disable;
    logic [47:0] exp;
    exp = {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'hFF};
    s_load_val(24'hABCDEF, 6'b000001, 6'b111110, 6'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (s_hex !== exp) begin
      failures++;
      $display("FAIL disable_abcdef: got %h want %h", s_hex, exp);
    end
  endtask

  task automatic test_back_to_back;
    s_load = 1'b1; s_data = 24'h111111;
    s_dots = '0; s_en = 6'h3F; s_blink = '0;
    @(posedge clk); #1;
    s_data = 24'h222222;
    @(posedge clk); #1;
    s_load = 1'b0;
    s_data = 24'h999999;
    @(negedge clk);
    checks++;
    if (s_hex !== {6{8'hF9}}) begin
      failures++;
      $display("FAIL hold_first: got %h want %h", s_hex, {6{8'hF9}});
    end
    @(negedge clk);
    checks++;
    if (s_hex !== {6{8'hA4}}) begin
      failures++;
      $display("FAIL hold_last: got %h want %h", s_hex, {6{8'hA4}});
    end
  endtask

  task automatic test_blink;
    logic [47:0] exp;
    logic [7:0] d0;
    s_load_val(24'h012345, 6'h00, 6'h3F, 6'b000001);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      d0 = 8'h92;
`ifdef YRV_SEVEN_SEG_BLINK_EN
      if (((cyc - 1) / 8) % 2 == 1) d0 = 8'hFF;
`endif
      exp = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, d0};
      checks++;
      if (s_hex !== exp) begin
        failures++;
        $display("FAIL blink_c%0d: got %h want %h", cyc, s_hex, exp);
      end
    end
  endtask

  task automatic test_scan;
    logic [11:0] exp;
    m_load_val(16'h8888, 4'hF);
    repeat (2) @(negedge clk);
    checks++;
    if (m_hex !== '1) begin
      failures++;
      $display("FAIL scan_hex_idle: got %h want ones", m_hex);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp = scan_model(cyc, 16'h8888);
      checks++;
      if ({m_dig, m_seg} !== exp) begin
        failures++;
        $display("FAIL scan_c%0d: got %h want %h",
          cyc, {m_dig, m_seg}, exp);
      end
    end
  endtask

  task automatic test_guard_load;
    logic [11:0] exp;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if ((cyc - 1) % 4 == 2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL guard_wait: got timeout want slot end");
    end
    m_load = 1'b1; m_data = 16'h1234;
    @(posedge clk); #1;
    m_load = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_dig, m_seg} !== 12'hFFF) begin
      failures++;
      $display("FAIL guard_cycle: got %h want fff", {m_dig, m_seg});
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp = scan_model(cyc, 16'h1234);
      checks++;
      if ({m_dig, m_seg} !== exp) begin
        failures++;
        $display("FAIL guard_load_c%0d: got %h want %h",
          cyc, {m_dig, m_seg}, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [11:0] exp;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if ((cyc - 1) % 4 == 1) found = 1'b1;
    end
    checks++;
    if (!found || m_dig === 4'hF) begin
      failures++;
      $display("FAIL mid_slot_wait: got %h want active", m_dig);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_dig, m_seg} !== 12'hFFF || s_hex !== {48{1'b1}}) begin
      failures++;
      $display("FAIL async_reset: got %h/%h want fff/ones",
        {m_dig, m_seg}, s_hex);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_load_val(16'h8888, 4'hF);
    @(negedge clk);
    checks++;
    if ({m_dig, m_seg} !== 12'hEFF) begin
      failures++;
      $display("FAIL restart_first: got %h want eff", {m_dig, m_seg});
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp = scan_model(cyc, 16'h8888);
      checks++;
      if ({m_dig, m_seg} !== exp) begin
        failures++;
        $display("FAIL restart_c%0d: got %h want %h",
          cyc, {m_dig, m_seg}, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_static_decode();
    test_disable();
    test_back_to_back();
    test_blink();
    test_scan();
    test_guard_load();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
